// File: rtl/redn_pkg.sv
// -----------------------------------------------------------------------------
// redn_pkg
// Shared definitions for the pipelined reduction unit (redn_pipe):
//   - redn_op_e      : reduction op encodings (OR / AND / XOR / NOR)
//   - redn_clog2     : ceil(log2(n)), used for the tree depth
//   - redn_cnt       : number of partial words held at a given tree level
//   - redn_ident_bit : identity element bit for an op (replicated to WIDTH)
// -----------------------------------------------------------------------------
package redn_pkg;

  typedef enum logic [1:0] {
    REDN_OR  = 2'b00,
    REDN_AND = 2'b01,
    REDN_XOR = 2'b10,
    REDN_NOR = 2'b11
  } redn_op_e;

  function automatic int unsigned redn_clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 1; i < n; i = i << 1) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Words alive at level lvl: ceil(n / 2^lvl). Level 0 is the operand vector.
  function automatic int unsigned redn_cnt(input int unsigned n, input int unsigned lvl);
    return (n + (32'd1 << lvl) - 32'd1) >> lvl;
  endfunction

  // AND pads with all-1; OR, XOR and NOR (which reduces with OR) pad with all-0.
  function automatic logic redn_ident_bit(input logic [1:0] op);
    return (op == REDN_AND);
  endfunction

endpackage

// File: rtl/redn_level.sv
// -----------------------------------------------------------------------------
// redn_level
// One level of the reduction tree: pairs up IN_CNT words, applies the node
// function, and registers ceil(IN_CNT/2) results together with valid and op.
// An odd trailing word is paired with the identity element of its op.
//
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   up_valid_i    : upstream level (or input port) holds a valid bundle
//   up_op_i       : op travelling with the upstream bundle
//   up_data_i     : IN_CNT words from upstream, word i at [i*WIDTH +: WIDTH]
//   dn_adv_i      : downstream level can take this level's contents
//   adv_o         : this level loads this cycle (empty or draining)
//   valid_o/op_o  : registered valid and op
//   data_o        : registered ceil(IN_CNT/2) partial words
// -----------------------------------------------------------------------------
module redn_level
  import redn_pkg::*;
#(
  parameter int unsigned IN_CNT = 2,
  parameter int unsigned WIDTH  = 16
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            up_valid_i,
  input  logic [1:0]                      up_op_i,
  input  logic [IN_CNT*WIDTH-1:0]         up_data_i,
  input  logic                            dn_adv_i,
  output logic                            adv_o,
  output logic                            valid_o,
  output logic [1:0]                      op_o,
  output logic [((IN_CNT+1)/2)*WIDTH-1:0] data_o
);

  localparam int unsigned OUT_CNT = (IN_CNT + 1) / 2;
  localparam int unsigned PAD_W   = 2 * OUT_CNT * WIDTH;

  logic [WIDTH-1:0]         ident;
  logic [PAD_W-1:0]         padded;
  logic [OUT_CNT*WIDTH-1:0] node;

  logic                     valid_q, valid_d;
  logic [1:0]               op_q, op_d;
  logic [OUT_CNT*WIDTH-1:0] data_q, data_d;

  // Fill every slot with the identity first, then overlay the real words,
  // so an odd IN_CNT leaves the identity in the last partner slot.
  always_comb begin
    ident  = {WIDTH{redn_ident_bit(up_op_i)}};
    padded = {(2*OUT_CNT){ident}};
    padded[IN_CNT*WIDTH-1:0] = up_data_i;
    node   = '0;
    for (int j = 0; j < int'(OUT_CNT); j++) begin
      case (up_op_i)
        REDN_AND: node[j*WIDTH +: WIDTH] = padded[2*j*WIDTH +: WIDTH] & padded[(2*j+1)*WIDTH +: WIDTH];
        REDN_XOR: node[j*WIDTH +: WIDTH] = padded[2*j*WIDTH +: WIDTH] ^ padded[(2*j+1)*WIDTH +: WIDTH];
        // NOR reduces with OR; the inversion happens once at the tree output.
        default:  node[j*WIDTH +: WIDTH] = padded[2*j*WIDTH +: WIDTH] | padded[(2*j+1)*WIDTH +: WIDTH];
      endcase
    end
  end

  // An empty level always loads, so bubbles collapse under a downstream stall.
  assign adv_o = !valid_q || dn_adv_i;

  always_comb begin
    valid_d = valid_q;
    op_d    = op_q;
    data_d  = data_q;
    if (adv_o) begin
      valid_d = up_valid_i;
      if (up_valid_i) begin
        op_d   = up_op_i;
        data_d = node;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      op_q    <= REDN_OR;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      op_q    <= op_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign op_o    = op_q;
  assign data_o  = data_q;

endmodule

// File: rtl/redn_pipe.sv
// -----------------------------------------------------------------------------
// redn_pipe
// Pipelined N_IN-input bitwise reduction (OR / AND / XOR / NOR) of WIDTH-bit
// operands. Binary tree of LAT = clog2(N_IN) registered levels with a
// valid/ready handshake on both sides; one bundle per cycle when unstalled.
//
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   in_valid_i    : operand bundle valid
//   in_ready_o    : bundle accepted this cycle (combinational from out_ready_i)
//   in_data_i     : operands, operand i at [i*WIDTH +: WIDTH]
//   in_op_i       : 00 OR, 01 AND, 10 XOR, 11 NOR
//   in_mask_i     : per-operand enable (REDN_PIPE_LANE_MASK_EN builds only)
//   out_valid_o   : result valid
//   out_ready_i   : consumer accepts result
//   out_data_o    : reduction result (held while stalled)
//   out_op_o      : op that produced out_data_o
//
// Build option: define REDN_PIPE_LANE_MASK_EN to add in_mask_i; masked-out
// operands are replaced by the op's identity before the first level.
// -----------------------------------------------------------------------------
module redn_pipe
  import redn_pkg::*;
#(
  parameter int unsigned N_IN  = 8,
  parameter int unsigned WIDTH = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [N_IN*WIDTH-1:0]   in_data_i,
  input  logic [1:0]              in_op_i,
`ifdef REDN_PIPE_LANE_MASK_EN
  input  logic [N_IN-1:0]         in_mask_i,
`endif
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [WIDTH-1:0]        out_data_o,
  output logic [1:0]              out_op_o
);

  localparam int unsigned LAT = redn_clog2(N_IN);

  logic [N_IN*WIDTH-1:0] opnd;

`ifdef REDN_PIPE_LANE_MASK_EN
  always_comb begin
    opnd = in_data_i;
    for (int i = 0; i < int'(N_IN); i++) begin
      if (!in_mask_i[i]) begin
        opnd[i*WIDTH +: WIDTH] = {WIDTH{redn_ident_bit(in_op_i)}};
      end
    end
  end
`else
  assign opnd = in_data_i;
`endif

  // Index 0 is the input port side; index LAT is the output register.
  logic       lvl_valid [0:LAT];
  logic [1:0] lvl_op    [0:LAT];
  logic       lvl_adv   [1:LAT+1];

  assign lvl_valid[0]     = in_valid_i;
  assign lvl_op[0]        = in_op_i;
  assign lvl_adv[LAT+1]   = !out_valid_o || out_ready_i;
  assign in_ready_o       = lvl_adv[1];

  for (genvar k = 1; k <= int'(LAT); k++) begin : gen_lvl
    localparam int unsigned IN_CNT  = redn_cnt(N_IN, k - 1);
    localparam int unsigned OUT_CNT = redn_cnt(N_IN, k);

    logic [IN_CNT*WIDTH-1:0]  up_data;
    logic [OUT_CNT*WIDTH-1:0] lvl_data;

    if (k == 1) begin : g_src
      assign up_data = opnd;
    end else begin : g_src
      assign up_data = gen_lvl[k-1].lvl_data;
    end

    redn_level #(
      .IN_CNT (IN_CNT),
      .WIDTH  (WIDTH)
    ) u_level (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .up_valid_i (lvl_valid[k-1]),
      .up_op_i    (lvl_op[k-1]),
      .up_data_i  (up_data),
      .dn_adv_i   (lvl_adv[k+1]),
      .adv_o      (lvl_adv[k]),
      .valid_o    (lvl_valid[k]),
      .op_o       (lvl_op[k]),
      .data_o     (lvl_data)
    );
  end

  logic [WIDTH-1:0] last_data;
  assign last_data = gen_lvl[LAT].lvl_data;

  // Inversion is driven from registered data/op only, so no in->out comb path.
  assign out_valid_o = lvl_valid[LAT];
  assign out_op_o    = lvl_op[LAT];
  assign out_data_o  = (lvl_op[LAT] == REDN_NOR) ? ~last_data : last_data;

endmodule
